// File: rtl/fetch_pkg.sv
// Shared widths, HALT opcode and state encoding for the instruction fetch unit.
package fetch_pkg;
    localparam int FETCH_ADDR_W = 4;
    localparam int FETCH_DATA_W = 8;
    localparam logic [7:0] FETCH_HALT_OP = 8'hFF;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        OFFER,
        STEP,
        HALT
    } fetch_state_t;
endpackage

// File: rtl/prog_mem_16x8.sv
// Program memory: flop array with one synchronous write port and a combinational read port.
module prog_mem_16x8 #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_reg [DEPTH];

    // Contents survive reset, so the words carry no reset term.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
        always_ff @(posedge clk) begin
            if (we && (waddr == ADDR_W'(gi))) begin
                mem_reg[gi] <= wdata;
            end
        end
    end

    assign rdata = mem_reg[raddr];
endmodule

// File: rtl/instr_fetch_unit.sv
// Fetches mem[PC], offers it over valid/ready and pulses EnableCount to advance the PC.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int ADDR_W = FETCH_ADDR_W,
    parameter int DATA_W = FETCH_DATA_W,
    parameter logic [DATA_W-1:0] HALT_OP = FETCH_HALT_OP
) (
    input  logic              MainClock,
    input  logic              ClearCounter,
    input  logic              Run,
    input  logic [ADDR_W-1:0] PC,
    input  logic              LoadEn,
    input  logic [ADDR_W-1:0] LoadAddr,
    input  logic [DATA_W-1:0] LoadData,
    output logic              EnableCount,
    output logic [DATA_W-1:0] Instr,
    output logic [ADDR_W-1:0] InstrAddr,
    output logic              InstrValid,
    input  logic              InstrReady,
    output logic              Halted,
    output logic              Busy
);
    fetch_state_t      state_reg, state_next;
    logic              enable_count_reg, enable_count_next;
    logic [DATA_W-1:0] instr_reg, instr_next;
    logic [ADDR_W-1:0] instr_addr_reg, instr_addr_next;
    logic              instr_valid_reg, instr_valid_next;
    logic              halted_reg, halted_next;
    logic              busy_reg, busy_next;
    logic [DATA_W-1:0] rd_data;
    logic              handshake;
    logic              is_halt;

    prog_mem_16x8 #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_mem (
        .clk   (MainClock),
        .we    (LoadEn),
        .waddr (LoadAddr),
        .wdata (LoadData),
        .raddr (PC),
        .rdata (rd_data)
    );

    assign handshake = instr_valid_reg && InstrReady;
    assign is_halt   = (instr_reg == HALT_OP);

    always_ff @(posedge MainClock or posedge ClearCounter) begin
        if (ClearCounter) begin
            state_reg        <= IDLE;
            enable_count_reg <= 1'b0;
            instr_reg        <= '0;
            instr_addr_reg   <= '0;
            instr_valid_reg  <= 1'b0;
            halted_reg       <= 1'b0;
            busy_reg         <= 1'b0;
        end else begin
            state_reg        <= state_next;
            enable_count_reg <= enable_count_next;
            instr_reg        <= instr_next;
            instr_addr_reg   <= instr_addr_next;
            instr_valid_reg  <= instr_valid_next;
            halted_reg       <= halted_next;
            busy_reg         <= busy_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (Run) state_next = FETCH;
            FETCH:   state_next = OFFER;
            // Run is deliberately ignored here: an offered instruction always completes.
            OFFER:   if (handshake) state_next = is_halt ? HALT : STEP;
            STEP:    state_next = Run ? FETCH : IDLE;
            HALT:    if (!Run) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        enable_count_next = 1'b0;
        instr_next        = instr_reg;
        instr_addr_next   = instr_addr_reg;
        instr_valid_next  = 1'b0;
        halted_next       = halted_reg;
        busy_next         = (state_next != IDLE);
        case (state_reg)
            FETCH: begin
                instr_next       = rd_data;
                instr_addr_next  = PC;
                instr_valid_next = 1'b1;
            end
            OFFER: begin
                instr_valid_next  = !handshake;
                enable_count_next = handshake && !is_halt;
                if (handshake && is_halt) halted_next = 1'b1;
            end
            HALT: begin
                if (!Run) halted_next = 1'b0;
            end
            default: ;
        endcase
    end

    assign EnableCount = enable_count_reg;
    assign Instr       = instr_reg;
    assign InstrAddr   = instr_addr_reg;
    assign InstrValid  = instr_valid_reg;
    assign Halted      = halted_reg;
    assign Busy        = busy_reg;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized and directed bench for instr_fetch_unit with an external PC counter model and scoreboard.
module tb_instr_fetch_unit;
    logic       MainClock = 1'b0;
    logic       ClearCounter = 1'b1;
    logic       Run = 1'b0;
    logic [3:0] PC;
    logic       LoadEn = 1'b0;
    logic [3:0] LoadAddr = '0;
    logic [7:0] LoadData = '0;
    logic       EnableCount;
    logic [7:0] Instr;
    logic [3:0] InstrAddr;
    logic       InstrValid;
    logic       InstrReady = 1'b0;
    logic       Halted;
    logic       Busy;

    int n_checks = 0;
    int n_fail = 0;
    int n_acc = 0;
    int n_nonhalt = 0;
    int pulses = 0;
    logic       en_prev = 1'b0;
    logic [7:0] model_mem [16];
    logic [3:0] exp_pc = '0;
    logic [3:0] last_addr = '0;
    logic       seen_wrap = 1'b0;

    instr_fetch_unit dut (
        .MainClock    (MainClock),
        .ClearCounter (ClearCounter),
        .Run          (Run),
        .PC           (PC),
        .LoadEn       (LoadEn),
        .LoadAddr     (LoadAddr),
        .LoadData     (LoadData),
        .EnableCount  (EnableCount),
        .Instr        (Instr),
        .InstrAddr    (InstrAddr),
        .InstrValid   (InstrValid),
        .InstrReady   (InstrReady),
        .Halted       (Halted),
        .Busy         (Busy)
    );

    always #5 MainClock = ~MainClock;

    // The program counter the fetch unit steers.
    always @(posedge MainClock or posedge ClearCounter) begin
        if (ClearCounter) PC <= '0;
        else if (EnableCount) PC <= PC + 4'd1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Scoreboard: accepted instructions must follow mem[0], mem[1], ... advancing only past non-HALT words.
    always @(negedge MainClock) begin
        if (EnableCount) begin
            pulses++;
            check("en_width", {31'd0, en_prev}, 32'd0);
        end
        en_prev = EnableCount;
        if (InstrValid && InstrReady) begin
            $display("ACC addr=%0d instr=%02h", InstrAddr, Instr);
            check("sb_instr", {24'd0, Instr}, {24'd0, model_mem[exp_pc]});
            check("sb_addr", {28'd0, InstrAddr}, {28'd0, exp_pc});
            if (n_acc > 0 && last_addr == 4'd15 && InstrAddr == 4'd0) seen_wrap = 1'b1;
            last_addr = InstrAddr;
            n_acc++;
            if (Instr != 8'hFF) begin
                exp_pc = exp_pc + 4'd1;
                n_nonhalt++;
            end
        end
    end

    task automatic load(input logic [3:0] a, input logic [7:0] d);
        @(posedge MainClock); #2;
        LoadEn = 1'b1; LoadAddr = a; LoadData = d;
        @(posedge MainClock); #2;
        LoadEn = 1'b0;
        model_mem[a] = d;
    endtask

    task automatic reset_dut();
        @(posedge MainClock); #2;
        ClearCounter = 1'b1; Run = 1'b0; InstrReady = 1'b0;
        @(posedge MainClock); #2;
        ClearCounter = 1'b0;
        exp_pc = '0;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 60; i++) begin
            @(posedge MainClock); #1;
            if (!Busy) break;
        end
        check(tag, {31'd0, Busy}, 32'd0);
    endtask

    task automatic wait_acc(input string tag, input int target, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(posedge MainClock); #2;
            if (n_acc >= target) break;
        end
        check(tag, {31'd0, n_acc >= target}, 32'd1);
    endtask

    initial begin
        int p0;
        #8;
        check("rst_enable", {31'd0, EnableCount}, 32'd0);
        check("rst_instr", {24'd0, Instr}, 32'd0);
        check("rst_addr", {28'd0, InstrAddr}, 32'd0);
        check("rst_valid", {31'd0, InstrValid}, 32'd0);
        check("rst_halted", {31'd0, Halted}, 32'd0);
        check("rst_busy", {31'd0, Busy}, 32'd0);
        @(posedge MainClock); #2;
        ClearCounter = 1'b0;

        for (int i = 0; i < 16; i++) load(4'(i), 8'($urandom_range(0, 254)));
        load(4'd0, 8'h11); load(4'd1, 8'h22); load(4'd2, 8'h33); load(4'd3, 8'h44);

        // Straight-line sequence with first-fetch latency.
        reset_dut();
        InstrReady = 1'b1; Run = 1'b1;
        @(posedge MainClock); #1;
        check("lat_edge1_valid", {31'd0, InstrValid}, 32'd0);
        check("lat_edge1_busy", {31'd0, Busy}, 32'd1);
        @(posedge MainClock); #1;
        check("lat_edge2_valid", {31'd0, InstrValid}, 32'd1);
        check("lat_edge2_instr", {24'd0, Instr}, 32'h11);
        wait_acc("seq_timeout", n_acc + 4, 40);
        Run = 1'b0;
        wait_idle("seq_idle");

        // Backpressure on the second instruction.
        reset_dut();
        p0 = n_acc;
        InstrReady = 1'b1; Run = 1'b1;
        wait_acc("bp_first", p0 + 1, 20);
        InstrReady = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge MainClock); #1;
            if (InstrValid) break;
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge MainClock); #1;
            check("bp_instr", {24'd0, Instr}, 32'h22);
            check("bp_valid", {31'd0, InstrValid}, 32'd1);
            check("bp_enable", {31'd0, EnableCount}, 32'd0);
        end
        #1 InstrReady = 1'b1;
        @(posedge MainClock); #1;
        check("bp_pulse", {31'd0, EnableCount}, 32'd1);
        check("bp_valid_drop", {31'd0, InstrValid}, 32'd0);
        @(posedge MainClock); #1;
        check("bp_pulse_end", {31'd0, EnableCount}, 32'd0);
        #1 Run = 1'b0;
        wait_idle("bp_idle");

        // HALT at address 2.
        reset_dut();
        load(4'd2, 8'hFF);
        InstrReady = 1'b1; Run = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(posedge MainClock); #1;
            if (Halted) break;
        end
        check("halt_reached", {31'd0, Halted}, 32'd1);
        check("halt_no_enable", {31'd0, EnableCount}, 32'd0);
        p0 = pulses;
        for (int i = 0; i < 4; i++) begin
            @(posedge MainClock); #1;
            check("halt_hold", {31'd0, Halted}, 32'd1);
            check("halt_valid", {31'd0, InstrValid}, 32'd0);
        end
        check("halt_pulses", 32'(pulses), 32'(p0));
        #1 Run = 1'b0;
        @(posedge MainClock); #1;
        check("halt_release", {31'd0, Halted}, 32'd0);
        check("halt_idle", {31'd0, Busy}, 32'd0);
        load(4'd2, 8'h33);

        // Random backpressure and Run toggling across the 15 -> 0 wrap.
        reset_dut();
        load(4'd15, 8'hA5); load(4'd0, 8'h5A);
        p0 = n_acc;
        Run = 1'b1;
        for (int i = 0; i < 600; i++) begin
            @(posedge MainClock); #2;
            InstrReady = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 19) == 0) Run = !Run;
            if (n_acc >= p0 + 22) break;
        end
        check("rand_progress", {31'd0, n_acc >= p0 + 22}, 32'd1);
        Run = 1'b0; InstrReady = 1'b1;
        wait_idle("rand_idle");
        check("wrap_seen", {31'd0, seen_wrap}, 32'd1);

        // Write to the fetched address during FETCH, then reset while offering.
        reset_dut();
        load(4'd0, 8'h11);
        @(posedge MainClock); #2;
        Run = 1'b1;
        @(posedge MainClock); #2;
        LoadEn = 1'b1; LoadAddr = 4'd0; LoadData = 8'h99;
        @(posedge MainClock); #2;
        LoadEn = 1'b0;
        model_mem[0] = 8'h99;
        check("rbw_instr", {24'd0, Instr}, 32'h11);
        check("rbw_addr", {28'd0, InstrAddr}, 32'd0);
        check("rbw_valid", {31'd0, InstrValid}, 32'd1);
        p0 = pulses;
        @(negedge MainClock); #1;
        ClearCounter = 1'b1;
        #1;
        check("mid_rst_valid", {31'd0, InstrValid}, 32'd0);
        check("mid_rst_busy", {31'd0, Busy}, 32'd0);
        @(posedge MainClock); #2;
        check("mid_rst_pulses", 32'(pulses), 32'(p0));
        ClearCounter = 1'b0; Run = 1'b0;
        exp_pc = '0;
        p0 = n_acc;
        InstrReady = 1'b1; Run = 1'b1;
        wait_acc("rbw_refetch", p0 + 1, 20);
        Run = 1'b0;
        wait_idle("final_idle");

        check("pulse_total", 32'(pulses), 32'(n_nonhalt));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
